// File: rtl/pwl_single_pole_filter.sv
// pwl_single_pole_filter: a bit-driven, slew-limited ramp feeds a first-order
// leaky integrator. A segment fitter emits piecewise-linear (value, slope)
// segments whenever the running linear prediction drifts more than ETOL from
// the filter output, or when the segment age counter is exhausted.
// Optional build macro PWL_SPF_SEGCNT_EN enables the saturating segment
// counter on seg_cnt; without it seg_cnt is tied to zero.
module pwl_single_pole_filter #(
  parameter int W      = 16,
  parameter int VH     = 3277,
  parameter int VL     = -3277,
  parameter int TR_CYC = 40,
  parameter int K      = 5,
  parameter int ETOL   = 33,
  parameter int AGE_W  = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic [W-1:0] seg_val,
  output logic [W-1:0] seg_slope,
  output logic         seg_upd,
  output logic [15:0]  seg_cnt
);

  localparam int STEP_RAW = (VH - VL) / TR_CYC;
  localparam int STEP     = (STEP_RAW < 1) ? 1 : STEP_RAW;
  localparam int AW       = W + K;          // accumulator width
  localparam int PW       = W + AGE_W + 1;  // prediction width

  localparam logic signed [W:0]    VH_E   = (W+1)'(VH);
  localparam logic signed [W:0]    VL_E   = (W+1)'(VL);
  localparam logic signed [W:0]    STEP_E = (W+1)'(STEP);
  localparam logic signed [W-1:0]  VL_S   = W'(VL);
  localparam logic signed [AW-1:0] ACC_RST = {VL_S, {K{1'b0}}};
  localparam logic [PW:0]          ETOL_E = (PW+1)'(ETOL);

  // State
  logic signed [W-1:0]  x_q;
  logic signed [AW-1:0] acc_q;
  logic signed [W-1:0]  y_prev_q;
  logic signed [W-1:0]  sv_q;
  logic signed [W-1:0]  sl_q;
  logic [AGE_W-1:0]     age_q;
  logic                 upd_q;

  // Ramp datapath (one extra bit so the step never wraps before clamping)
  logic signed [W:0]   x_e, tgt_e, x_up, x_dn;
  logic signed [W-1:0] x_nxt;

  // Filter datapath
  logic signed [AW-1:0] acc_shr, x_sx, acc_nxt;
  logic signed [W-1:0]  y_s;

  // Fitter datapath
  logic [AGE_W:0]       age_p1;
  logic signed [PW-1:0] sl_e, age_e, sv_e, y_e, pred;
  logic signed [PW:0]   diff;
  logic [PW:0]          err;
  logic                 new_seg;
  logic signed [W-1:0]  slope_nxt;

  // Slew-limited ramp toward the rail selected by in; reversal starts from current x
  always_comb begin
    x_e   = {x_q[W-1], x_q};
    tgt_e = in ? VH_E : VL_E;
    x_up  = x_e + STEP_E;
    x_dn  = x_e - STEP_E;
    x_nxt = x_q;
    if (x_e < tgt_e) begin
      x_nxt = (x_up > tgt_e) ? tgt_e[W-1:0] : x_up[W-1:0];
    end else if (x_e > tgt_e) begin
      x_nxt = (x_dn < tgt_e) ? tgt_e[W-1:0] : x_dn[W-1:0];
    end
  end

  assign acc_shr = acc_q >>> K;
  assign x_sx    = {{K{x_q[W-1]}}, x_q};
  assign acc_nxt = acc_q + x_sx - acc_shr;
  assign y_s     = acc_q[AW-1:K];  // equals acc_q >>> K, which always fits W bits

  // Linear prediction one cycle ahead of the segment's current age, and its error
  always_comb begin
    age_p1    = {1'b0, age_q} + {{AGE_W{1'b0}}, 1'b1};
    sl_e      = {{(PW-W){sl_q[W-1]}}, sl_q};
    sv_e      = {{(PW-W){sv_q[W-1]}}, sv_q};
    y_e       = {{(PW-W){y_s[W-1]}}, y_s};
    age_e     = {{(PW-AGE_W-1){1'b0}}, age_p1};
    pred      = sv_e + sl_e * age_e;
    diff      = {y_e[PW-1], y_e} - {pred[PW-1], pred};
    err       = diff[PW] ? -diff : diff;
    new_seg   = (err > ETOL_E) || (age_q == '1);
    slope_nxt = y_s - y_prev_q;
  end

  // Ramp, filter and fitter registers; reset discards the whole pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= VL_S;
      acc_q    <= ACC_RST;
      y_prev_q <= VL_S;
      sv_q     <= VL_S;
      sl_q     <= '0;
      age_q    <= '0;
      upd_q    <= 1'b0;
    end else begin
      x_q      <= x_nxt;
      acc_q    <= acc_nxt;
      y_prev_q <= y_s;
      if (new_seg) begin
        sv_q  <= y_s;
        sl_q  <= slope_nxt;
        age_q <= '0;
        upd_q <= 1'b1;
      end else begin
        age_q <= age_q + {{(AGE_W-1){1'b0}}, 1'b1};
        upd_q <= 1'b0;
      end
    end
  end

`ifdef PWL_SPF_SEGCNT_EN
  logic [15:0] cnt_q;

  // Saturating count of emitted segment strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else if (upd_q && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign seg_cnt = cnt_q;
`else
  assign seg_cnt = 16'd0;
`endif

  assign x         = x_q;
  assign y         = y_s;
  assign seg_val   = sv_q;
  assign seg_slope = sl_q;
  assign seg_upd   = upd_q;

endmodule

// File: tb/tb_pwl_single_pole_filter.sv
// Bench for pwl_single_pole_filter. Two instances share the stimulus: one with
// the default 16-bit segment age and one with a 4-bit age to exercise forced
// segment updates. A behavioural model predicts every output; each cycle's
// expectation is queued when the input is driven and popped after the edge.
module tb_pwl_single_pole_filter;

  localparam int VH   = 3277;
  localparam int VL   = -3277;
  localparam int STEP = 163;
  localparam int ETOL = 33;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in  = 1'b0;

  logic [15:0] x_a, y_a, sv_a, sl_a, cnt_a;
  logic [15:0] x_b, y_b, sv_b, sl_b, cnt_b;
  logic        upd_a, upd_b;

  pwl_single_pole_filter dut_a (
    .clk(clk), .rst(rst), .in(in),
    .x(x_a), .y(y_a), .seg_val(sv_a), .seg_slope(sl_a),
    .seg_upd(upd_a), .seg_cnt(cnt_a)
  );

  pwl_single_pole_filter #(.AGE_W(4)) dut_b (
    .clk(clk), .rst(rst), .in(in),
    .x(x_b), .y(y_b), .seg_val(sv_b), .seg_slope(sl_b),
    .seg_upd(upd_b), .seg_cnt(cnt_b)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard entry: expected outputs after one edge
  typedef struct {
    int   x;
    int   y;
    int   yfit;
    logic rst;
    int   sv0, sl0, upd0, cnt0;
    int   sv1, sl1, upd1, cnt1;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Model state (index 0: dut_a, index 1: dut_b)
  int m_x   = VL;
  int m_acc = VL * 32;
  int m_yp  = VL;
  int m_sv  [2] = '{VL, VL};
  int m_sl  [2] = '{0, 0};
  int m_age [2] = '{0, 0};
  int m_upd [2] = '{0, 0};
  int m_cnt [2] = '{0, 0};
  int age_max [2] = '{65535, 15};

  // Observed segment age per instance, rebuilt from the update strobes
  int age_obs [2] = '{0, 0};

  task automatic check_val(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int sx16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  function automatic longint labs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  // Advance the reference model by one edge and return the expected outputs
  task automatic model_step(input logic r, input logic i, output exp_t e);
    int     tgt, nx, nacc, y_cur;
    longint p, d;
    y_cur  = m_acc >>> 5;
    e.yfit = y_cur;
    e.rst  = r;
    if (r) begin
      m_x   = VL;
      m_acc = VL * 32;
      m_yp  = VL;
      for (int k = 0; k < 2; k++) begin
        m_sv[k] = VL; m_sl[k] = 0; m_age[k] = 0; m_upd[k] = 0; m_cnt[k] = 0;
      end
    end else begin
      tgt = i ? VH : VL;
      nx  = m_x;
      if (m_x < tgt) nx = (m_x + STEP > tgt) ? tgt : m_x + STEP;
      else if (m_x > tgt) nx = (m_x - STEP < tgt) ? tgt : m_x - STEP;
      nacc = m_acc + m_x - (m_acc >>> 5);
      for (int k = 0; k < 2; k++) begin
`ifdef PWL_SPF_SEGCNT_EN
        if (m_upd[k] != 0 && m_cnt[k] != 65535) m_cnt[k]++;
`endif
        p = longint'(m_sv[k]) + longint'(m_sl[k]) * longint'(m_age[k] + 1);
        d = labs(longint'(y_cur) - p);
        if (d > ETOL || m_age[k] == age_max[k]) begin
          m_sv[k]  = y_cur;
          m_sl[k]  = sx16(y_cur - m_yp);
          m_age[k] = 0;
          m_upd[k] = 1;
        end else begin
          m_age[k] = m_age[k] + 1;
          m_upd[k] = 0;
        end
      end
      m_yp  = y_cur;
      m_x   = nx;
      m_acc = nacc;
    end
    e.x    = m_x;
    e.y    = m_acc >>> 5;
    e.sv0  = m_sv[0]; e.sl0 = m_sl[0]; e.upd0 = m_upd[0]; e.cnt0 = m_cnt[0];
    e.sv1  = m_sv[1]; e.sl1 = m_sl[1]; e.upd1 = m_upd[1]; e.cnt1 = m_cnt[1];
  endtask

  // Error bound of the published segment against the y it was fitted on
  task automatic check_inv(input string tag, input int k, input exp_t e,
                           input logic upd, input logic [15:0] sv, input logic [15:0] sl);
    longint lin;
    if (e.rst || upd) age_obs[k] = 0;
    else age_obs[k] = age_obs[k] + 1;
    if (!e.rst && !upd) begin
      lin = longint'(s16(sv)) + longint'(s16(sl)) * longint'(age_obs[k]);
      check_val(tag, (labs(longint'(e.yfit) - lin) <= ETOL) ? 1 : 0, 1);
    end
  endtask

  // Compare the DUT outputs after an edge against the oldest expectation
  task automatic compare_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check_val("x_a",    s16(x_a),  e.x);
    check_val("y_a",    s16(y_a),  e.y);
    check_val("sv_a",   s16(sv_a), e.sv0);
    check_val("sl_a",   s16(sl_a), e.sl0);
    check_val("upd_a",  upd_a,     e.upd0);
    check_val("cnt_a",  cnt_a,     e.cnt0);
    check_val("x_b",    s16(x_b),  e.x);
    check_val("y_b",    s16(y_b),  e.y);
    check_val("sv_b",   s16(sv_b), e.sv1);
    check_val("sl_b",   s16(sl_b), e.sl1);
    check_val("upd_b",  upd_b,     e.upd1);
    check_val("cnt_b",  cnt_b,     e.cnt1);
    check_inv("inv_a", 0, e, upd_a, sv_a, sl_a);
    check_inv("inv_b", 1, e, upd_b, sv_b, sl_b);
  endtask

  // Driver: one clock of stimulus, with its expectation queued up front
  task automatic tick(input logic r, input logic i);
    exp_t e;
    @(negedge clk);
    rst = r;
    in  = i;
    model_step(r, i, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic ticks(input int n, input logic r, input logic i);
    for (int j = 0; j < n; j++) tick(r, i);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_x"},   s16(x_a),  VL);
    check_val({tag, "_y"},   s16(y_a),  VL);
    check_val({tag, "_sv"},  s16(sv_a), VL);
    check_val({tag, "_sl"},  s16(sl_a), 0);
    check_val({tag, "_upd"}, upd_a,     0);
    check_val({tag, "_cnt"}, cnt_a,     0);
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Main sequence
  initial begin
    int y_last, n_upd, last_idx, cnt_start, xe, len;
    logic ri;

    // Reset held 3 cycles with in high
    ticks(3, 1'b1, 1'b1);
    check_reset_vals("rst");

    // Rising step, then settle
    ticks(5, 1'b0, 1'b0);
    y_last = s16(y_a);
    n_upd  = 0;
    for (int n = 1; n <= 600; n++) begin
      tick(1'b0, 1'b1);
      if (n <= 45) begin
        xe = VL + STEP * n;
        if (xe > VH) xe = VH;
        check_val("ramp_x", s16(x_a), xe);
      end
      check_val("y_monotonic", (s16(y_a) >= y_last) ? 1 : 0, 1);
      y_last = s16(y_a);
      if (n > 500 && upd_a) n_upd++;
    end
    check_val("settle_y", (labs(longint'(VH - s16(y_a))) <= 32) ? 1 : 0, 1);
    check_val("settle_no_upd", n_upd, 0);

    // 1/100/0 pulse sequence
    ticks(100, 1'b0, 1'b1);
    ticks(500, 1'b0, 1'b0);

    // Mid-ramp reversal
    ticks(10, 1'b0, 1'b1);
    check_val("rev_peak", s16(x_a), VL + 10 * STEP);
    for (int n = 1; n <= 60; n++) begin
      tick(1'b0, 1'b0);
      xe = VL + 10 * STEP - STEP * n;
      if (xe < VL) xe = VL;
      check_val("rev_x", s16(x_a), xe);
    end

    // Reset in the middle of a rising ramp
    ticks(20, 1'b0, 1'b1);
    tick(1'b1, 1'b1);
    check_reset_vals("midrst");
    tick(1'b0, 1'b1);
    check_val("restart_x", s16(x_a), VL + STEP);

    // Settle high, then watch forced updates on the 4-bit-age instance
    ticks(500, 1'b0, 1'b1);
    n_upd     = 0;
    last_idx  = -1;
    cnt_start = cnt_b;
    for (int n = 0; n < 64; n++) begin
      tick(1'b0, 1'b1);
      check_val("sat_no_upd_a", upd_a, 0);
      if (upd_b) begin
        n_upd++;
        check_val("sat_slope_b", s16(sl_b), 0);
        check_val("sat_val_b", s16(sv_b), VH);
        if (last_idx >= 0) check_val("sat_period_b", n - last_idx, 16);
        last_idx = n;
      end
    end
    check_val("sat_count_b", n_upd, 4);
    tick(1'b0, 1'b1);
`ifdef PWL_SPF_SEGCNT_EN
    check_val("sat_cnt_b", cnt_b - cnt_start, 4);
`else
    check_val("sat_cnt_b", cnt_b - cnt_start, 0);
`endif

    // Randomised bursts with occasional resets
    for (int s = 0; s < 25; s++) begin
      ri  = 1'($urandom_range(0, 1));
      len = $urandom_range(3, 40);
      if ($urandom_range(0, 9) == 0) tick(1'b1, ri);
      ticks(len, 1'b0, ri);
    end

    check_val("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
